// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, CP0 field positions and FSM state type for the
// WB-to-CP0 exception sequencer.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h1f;

  localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;

  localparam int SR_IE  = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LSB = 8;
  localparam int IM_MSB = 15;
  localparam int IP_LSB = 8;
  localparam int IP_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } exc_state_e;

  // CP0 rewinds EPC by 4 for delay-slot faults, except when the fault is the
  // fetch itself (the slot PC is then the faulting PC).
  function automatic logic [31:0] epc_src(input logic [31:0] pc,
                                          input logic        bd,
                                          input logic        pc_error);
    return (bd && !pc_error) ? pc + 32'd4 : pc;
  endfunction

endpackage

// File: rtl/exc_int_sync.sv
// Interrupt request combine plus one sampling register, giving the sequencer
// a stable one-cycle-late view of pending interrupts.
module exc_int_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ip_i,
  input  logic [7:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  output logic       int_q_o
);

  logic int_req;
  logic int_q;

  assign int_req = ie_i & ~exl_i & (|(ip_i & im_i));

  always_ff @(posedge clk) begin
    if (reset) begin
      int_q <= 1'b0;
    end else begin
      int_q <= int_req;
    end
  end

  assign int_q_o = int_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: picks the trap cause for the WB instruction,
// pulses the CP0 commit inputs and runs flush/redirect toward IF.
//
// state | meaning
// IDLE  | watching WB for interrupt, exception or ERET
// FLUSH | younger stages killed, counting down the flush window
// REDIR | flush held, redirect offered to IF until accepted
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEF,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [4:0]  ws_ex_code,
  input  logic        ws_eret,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_pc_error,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  input  logic        fs_redirect_ready,
  output logic [4:0]  cp0_ex_code,
  output logic        cp0_bd,
  output logic        cp0_eret,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        int_q;
  logic        take_int, take_exc, take_eret, trigger;

  logic [4:0]  ex_code_q, ex_code_d;
  logic        bd_q, bd_d;
  logic        eret_q, eret_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_cause[31:16], cp0_cause[7:0],
                             cp0_status[31:16], cp0_status[7:2]};

  exc_int_sync u_int_sync (
    .clk     (clk),
    .reset   (reset),
    .ip_i    (cp0_cause[IP_MSB:IP_LSB]),
    .im_i    (cp0_status[IM_MSB:IM_LSB]),
    .ie_i    (cp0_status[SR_IE]),
    .exl_i   (cp0_status[SR_EXL]),
    .int_q_o (int_q)
  );

  // Interrupt outranks everything; ERET only when nothing else is pending.
  always_comb begin
    take_int  = int_q;
    take_exc  = ~int_q & (ws_ex_code != EXC_NONE);
    take_eret = ~int_q & (ws_ex_code == EXC_NONE) & ws_eret;
    trigger   = (state_q == ST_IDLE) & ws_valid & (take_int | take_exc | take_eret);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    busy           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        pipe_flush = 1'b1;
        busy       = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_REDIR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_REDIR: begin
        pipe_flush     = 1'b1;
        redirect_valid = 1'b1;
        busy           = 1'b1;
        if (fs_redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit outputs are a single-cycle pulse; every non-trigger cycle reloads idle values.
  always_comb begin
    ex_code_d  = EXC_NONE;
    bd_d       = 1'b0;
    eret_d     = 1'b0;
    pc_d       = '0;
    badvaddr_d = '0;
    redir_pc_d = redir_pc_q;
    if (trigger) begin
      ex_code_d  = take_int ? EXC_INT : (take_exc ? ws_ex_code : EXC_NONE);
      eret_d     = take_eret;
      bd_d       = ws_bd;
      pc_d       = epc_src(ws_pc, ws_bd, ws_pc_error);
      badvaddr_d = ws_badvaddr;
      redir_pc_d = take_eret ? cp0_epc : EX_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_code_q  <= EXC_NONE;
      bd_q       <= 1'b0;
      eret_q     <= 1'b0;
      pc_q       <= '0;
      badvaddr_q <= '0;
      redir_pc_q <= '0;
    end else begin
      ex_code_q  <= ex_code_d;
      bd_q       <= bd_d;
      eret_q     <= eret_d;
      pc_q       <= pc_d;
      badvaddr_q <= badvaddr_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign cp0_ex_code  = ex_code_q;
  assign cp0_bd       = bd_q;
  assign cp0_eret     = eret_q;
  assign cp0_pc       = pc_q;
  assign cp0_badvaddr = badvaddr_q;
  assign redirect_pc  = redir_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed traps push expected commits,
// redirects and flush lengths; a monitor thread pops and compares them.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        ws_valid;
  logic [4:0]  ws_ex_code;
  logic        ws_eret;
  logic        ws_bd;
  logic [31:0] ws_pc;
  logic [31:0] ws_badvaddr;
  logic        ws_pc_error;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        fs_redirect_ready;
  logic [4:0]  cp0_ex_code;
  logic        cp0_bd;
  logic        cp0_eret;
  logic [31:0] cp0_pc;
  logic [31:0] cp0_badvaddr;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  exc_ctrl #(.EX_ENTRY(32'hbfc00380), .FLUSH_CYCLES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_valid          (ws_valid),
    .ws_ex_code        (ws_ex_code),
    .ws_eret           (ws_eret),
    .ws_bd             (ws_bd),
    .ws_pc             (ws_pc),
    .ws_badvaddr       (ws_badvaddr),
    .ws_pc_error       (ws_pc_error),
    .cp0_cause         (cp0_cause),
    .cp0_status        (cp0_status),
    .cp0_epc           (cp0_epc),
    .fs_redirect_ready (fs_redirect_ready),
    .cp0_ex_code       (cp0_ex_code),
    .cp0_bd            (cp0_bd),
    .cp0_eret          (cp0_eret),
    .cp0_pc            (cp0_pc),
    .cp0_badvaddr      (cp0_badvaddr),
    .pipe_flush        (pipe_flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic        bd;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] bad;
  } commit_t;

  commit_t     commit_q[$];
  logic [31:0] redir_q[$];
  int          flush_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  int          flush_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    commit_t     e;
    logic [31:0] r;
    int          fl;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cp0_ex_code !== EXC_NONE || cp0_eret !== 1'b0) begin
          if (commit_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_commit: got code %h eret %b pc %h expected no commit",
                     cp0_ex_code, cp0_eret, cp0_pc);
          end else begin
            e = commit_q.pop_front();
            chk("commit_code", 32'(cp0_ex_code), 32'(e.code));
            chk("commit_bd", 32'(cp0_bd), 32'(e.bd));
            chk("commit_eret", 32'(cp0_eret), 32'(e.eret));
            chk("commit_pc", cp0_pc, e.pc);
            chk("commit_badvaddr", cp0_badvaddr, e.bad);
          end
        end
        if (redirect_valid === 1'b1 && fs_redirect_ready === 1'b1) begin
          if (redir_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
          end else begin
            r = redir_q.pop_front();
            chk("redirect_pc", redirect_pc, r);
          end
        end
        if (pipe_flush === 1'b1) begin
          flush_run++;
        end else if (flush_run != 0) begin
          if (flush_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_flush: got %0d flush cycles expected none", flush_run);
          end else begin
            fl = flush_q.pop_front();
            chk("flush_len", 32'(flush_run), 32'(fl));
          end
          flush_run = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_trap(input logic [4:0] code, input logic bd, input logic eret,
                             input logic [31:0] pc, input logic [31:0] bad,
                             input bit has_redir, input logic [31:0] redir, input int flen);
    commit_t c;
    c.code = code; c.bd = bd; c.eret = eret; c.pc = pc; c.bad = bad;
    commit_q.push_back(c);
    if (has_redir) redir_q.push_back(redir);
    flush_q.push_back(flen);
  endtask

  task automatic drive_ws(input logic [4:0] code, input logic eret, input logic bd,
                          input logic perr, input logic [31:0] pc, input logic [31:0] bad);
    ws_valid = 1'b1; ws_ex_code = code; ws_eret = eret; ws_bd = bd;
    ws_pc_error = perr; ws_pc = pc; ws_badvaddr = bad;
    step();
    ws_valid = 1'b0; ws_ex_code = EXC_NONE; ws_eret = 1'b0; ws_bd = 1'b0; ws_pc_error = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      if (busy === 1'b0) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: got busy=1 after 40 cycles expected 0", name);
    end
  endtask

  initial begin
    bit seen;
    fork
      monitor();
    join_none

    reset = 1'b1; ws_valid = 1'b0; ws_ex_code = EXC_NONE; ws_eret = 1'b0; ws_bd = 1'b0;
    ws_pc = '0; ws_badvaddr = '0; ws_pc_error = 1'b0; cp0_cause = '0; cp0_status = '0;
    cp0_epc = '0; fs_redirect_ready = 1'b1;
    repeat (3) step();

    chk("rst_ex_code", 32'(cp0_ex_code), 32'h1f);
    chk("rst_bd", 32'(cp0_bd), 32'h0);
    chk("rst_eret", 32'(cp0_eret), 32'h0);
    chk("rst_pipe_flush", 32'(pipe_flush), 32'h0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cp0_pc", cp0_pc, 32'h0);
    chk("rst_badvaddr", cp0_badvaddr, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    // SYS trap with explicit latency checks
    expect_trap(EXC_SYS, 1'b0, 1'b0, 32'hbfc00100, 32'h0, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_SYS, 1'b0, 1'b0, 1'b0, 32'hbfc00100, 32'h0);
    chk("sys_code_next_cycle", 32'(cp0_ex_code), 32'h08);
    chk("sys_busy", 32'(busy), 32'h1);
    step();
    chk("sys_pulse_cleared", 32'(cp0_ex_code), 32'h1f);
    step();
    chk("sys_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("sys_redirect_pc", redirect_pc, 32'hbfc00380);
    wait_idle("sys");

    // Delay-slot EPC handling
    expect_trap(EXC_OV, 1'b1, 1'b0, 32'h00001008, 32'h0, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_OV, 1'b0, 1'b1, 1'b0, 32'h00001004, 32'h0);
    wait_idle("ov_bd");
    expect_trap(EXC_ADEL, 1'b1, 1'b0, 32'h00001004, 32'h00001006, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_ADEL, 1'b0, 1'b1, 1'b1, 32'h00001004, 32'h00001006);
    wait_idle("adel_bd");
    expect_trap(EXC_ADES, 1'b0, 1'b0, 32'h00004000, 32'h80000001, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_ADES, 1'b0, 1'b0, 1'b0, 32'h00004000, 32'h80000001);
    wait_idle("ades");

    // Interrupt: IE=1, IM7=1, EXL=0, IP7 raised one cycle ahead
    cp0_status = 32'h00408001;
    cp0_cause  = 32'h00008000;
    step();
    expect_trap(EXC_INT, 1'b0, 1'b0, 32'h00002000, 32'h0, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_NONE, 1'b0, 1'b0, 1'b0, 32'h00002000, 32'h0);
    cp0_cause = 32'h0;
    wait_idle("int");

    // Interrupt beats a simultaneous SYS
    cp0_cause = 32'h00008000;
    step();
    expect_trap(EXC_INT, 1'b0, 1'b0, 32'h00002100, 32'h0, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_SYS, 1'b0, 1'b0, 1'b0, 32'h00002100, 32'h0);
    cp0_cause = 32'h0;
    wait_idle("int_sys");

    // Interrupt beats ERET; redirect goes to the exception entry, not EPC
    cp0_epc = 32'hbfc00200;
    cp0_cause = 32'h00008000;
    step();
    expect_trap(EXC_INT, 1'b0, 1'b0, 32'h00002200, 32'h0, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_NONE, 1'b1, 1'b0, 1'b0, 32'h00002200, 32'h0);
    cp0_cause = 32'h0;
    wait_idle("int_eret");

    // EXL=1 masks the interrupt
    cp0_status = 32'h00408003;
    cp0_cause  = 32'h00008000;
    step();
    drive_ws(EXC_NONE, 1'b0, 1'b0, 1'b0, 32'h00002300, 32'h0);
    drive_ws(EXC_NONE, 1'b0, 1'b0, 1'b0, 32'h00002304, 32'h0);
    chk("exl_no_trap_busy", 32'(busy), 32'h0);
    chk("exl_no_trap_flush", 32'(pipe_flush), 32'h0);
    cp0_cause = 32'h0;
    cp0_status = 32'h0;

    // ERET: redirect to EPC sampled at the trigger edge
    cp0_epc = 32'hbfc00200;
    expect_trap(EXC_NONE, 1'b0, 1'b1, 32'h00003000, 32'h0, 1'b1, 32'hbfc00200, 3);
    drive_ws(EXC_NONE, 1'b1, 1'b0, 1'b0, 32'h00003000, 32'h0);
    cp0_epc = 32'h12345678;
    chk("eret_pulse", 32'(cp0_eret), 32'h1);
    wait_idle("eret");
    expect_trap(EXC_NONE, 1'b1, 1'b1, 32'h00003008, 32'h0, 1'b1, 32'h12345678, 3);
    drive_ws(EXC_NONE, 1'b1, 1'b1, 1'b0, 32'h00003004, 32'h0);
    wait_idle("eret_bd");

    // Backpressure: 5 extra REDIR cycles, second exception ignored
    fs_redirect_ready = 1'b0;
    expect_trap(EXC_BP, 1'b0, 1'b0, 32'h00005000, 32'h0, 1'b1, 32'hbfc00380, 8);
    drive_ws(EXC_BP, 1'b0, 1'b0, 1'b0, 32'h00005000, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (redirect_valid === 1'b1) seen = 1'b1;
      else step();
    end
    chk("bp_reached_redir", 32'(seen), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_redirect_held", 32'(redirect_valid), 32'h1);
      chk("bp_flush_held", 32'(pipe_flush), 32'h1);
      ws_valid = 1'b1; ws_ex_code = EXC_RI; ws_pc = 32'h00005004;
      step();
    end
    ws_valid = 1'b0; ws_ex_code = EXC_NONE;
    fs_redirect_ready = 1'b1;
    step();
    chk("bp_idle_after_release", 32'(busy), 32'h0);
    chk("bp_redirect_dropped", 32'(redirect_valid), 32'h0);

    // Reset during FLUSH
    expect_trap(EXC_SYS, 1'b0, 1'b0, 32'h00006000, 32'h0, 1'b0, 32'h0, 1);
    drive_ws(EXC_SYS, 1'b0, 1'b0, 1'b0, 32'h00006000, 32'h0);
    reset = 1'b1;
    step();
    chk("rstflush_busy", 32'(busy), 32'h0);
    chk("rstflush_pipe_flush", 32'(pipe_flush), 32'h0);
    chk("rstflush_ex_code", 32'(cp0_ex_code), 32'h1f);
    chk("rstflush_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rstflush_redirect_pc", redirect_pc, 32'h0);
    reset = 1'b0;
    step();

    // Normal trap after reset recovery
    expect_trap(EXC_RI, 1'b0, 1'b0, 32'h00007000, 32'h0, 1'b1, 32'hbfc00380, 3);
    drive_ws(EXC_RI, 1'b0, 1'b0, 1'b0, 32'h00007000, 32'h0);
    wait_idle("ri");

    repeat (3) step();
    chk("leftover_commits", 32'(commit_q.size()), 32'h0);
    chk("leftover_redirects", 32'(redir_q.size()), 32'h0);
    chk("leftover_flushes", 32'(flush_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer between the WB stage and CP0.
- Decides when a committed instruction traps: pending interrupt, instruction exception, or ERET.
- Drives the CP0 control/write inputs (ex_code, bd, eret, BadVAddr, EPC source) as a one-cycle commit pulse.
- Runs a flush/redirect FSM so IF restarts at the exception entry or at EPC.

Parameters:
- EX_ENTRY, 32'hbfc00380, exception entry PC (BEV=1).
- FLUSH_CYCLES, 2, cycles flush is held after commit (range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_valid  in  1  WB holds a valid instruction this cycle
- ws_ex_code  in  5  WB instruction exception code; `NO_EX if none
- ws_eret  in  1  WB instruction is ERET
- ws_bd  in  1  WB instruction is in a delay slot
- ws_pc  in  32  WB instruction PC
- ws_badvaddr  in  32  faulting address for ADEL/ADES
- ws_pc_error  in  1  fault is an instruction-fetch address error
- cp0_cause  in  32  CP0 Cause (IP at [15:8])
- cp0_status  in  32  CP0 Status (IM [15:8], EXL [1], IE [0])
- cp0_epc  in  32  CP0 EPC
- fs_redirect_ready  in  1  IF accepts redirect this cycle
- cp0_ex_code  out  5  code to CP0; `NO_EX except in the commit cycle
- cp0_bd  out  1  BD to CP0
- cp0_eret  out  1  ERET pulse to CP0
- cp0_pc  out  32  EPC source to CP0
- cp0_badvaddr  out  32  BadVAddr to CP0
- pipe_flush  out  1  kill all stages younger than WB
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  32  redirect target
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - FSM IDLE
  - cp0_ex_code=`NO_EX
  - cp0_bd, cp0_eret, pipe_flush, redirect_valid, busy = 0
  - cp0_pc, cp0_badvaddr, redirect_pc = 0
- int_req = cp0_status[0] & ~cp0_status[1] & |(cp0_cause[15:8] & cp0_status[15:8]). This is combinational; it is registered once into int_q, giving 1-cycle interrupt sampling latency.
- Trigger evaluation happens only in IDLE with ws_valid=1. Priority:
  - int_q -> code `INT (5'h00)
  - else ws_ex_code != `NO_EX -> ws_ex_code
  - else ws_eret -> eret
- Commit cycle (registered; outputs valid the cycle after the trigger):
  - cp0_ex_code is the selected code, or `NO_EX for ERET.
  - cp0_eret=1 for ERET only.
  - cp0_bd=ws_bd.
  - cp0_pc=ws_pc, or ws_pc+4 when ws_bd & ~ws_pc_error (CP0 subtracts 4).
  - cp0_badvaddr=ws_badvaddr.
  - All CP0 outputs return to idle values the next cycle.
- FSM states:
  - IDLE: on trigger -> FLUSH. Latch redirect_pc = EX_ENTRY, or cp0_epc for ERET (cp0_epc sampled at the trigger edge). Load flush counter = FLUSH_CYCLES-1.
  - FLUSH: pipe_flush=1. Counter decrements each cycle; at 0 -> REDIR.
  - REDIR: redirect_valid=1, pipe_flush=1, and both hold until fs_redirect_ready. Transfer at redirect_valid & fs_redirect_ready -> IDLE.
- busy=1 in FLUSH and REDIR.
- Triggers, ws_* inputs and int_req are ignored while busy; no second commit occurs before IDLE.
- An interrupt that arrives during the flush is serviced on the first valid WB instruction after IDLE, provided CP0 EXL is still 0.
- Simultaneous interrupt + instruction exception: only the interrupt is reported; the instruction re-executes after ERET.
- ERET with int_q=1: the interrupt wins and ERET is not signalled.
- reset in any state -> IDLE with reset values next cycle. No partial pulse is emitted.
- fs_redirect_ready already high on REDIR entry: a 1-cycle REDIR.
- Minimum trap-to-IDLE = 1 + FLUSH_CYCLES + 1 cycles.

Decomposition:
- Shared package/header (mycpu.h): `NO_EX, `INT, `ADEL, `ADES, `SYS, `BP, `RI, `OV exception codes, the EX_ENTRY default, and CP0 field bit positions (IE, EXL, IM, IP).
- One natural sub-module: exc_int_sync (the int_req combine and int_q register). Everything else stays in exc_ctrl.

Test Plan:
- Exception trap: ws_valid=1, ws_ex_code=`SYS, ws_pc=32'hbfc00100, ws_bd=0, fs_redirect_ready=1.
  - Next cycle: cp0_ex_code=`SYS, cp0_pc=32'hbfc00100.
  - pipe_flush high 3 cycles; redirect_pc=32'hbfc00380; then IDLE.
- Delay slot: ws_bd=1, ws_pc=32'h1004, ws_ex_code=`OV -> cp0_pc=32'h1008, cp0_bd=1. Repeat with ws_pc_error=1 and ws_ex_code=`ADEL -> cp0_pc=32'h1004, cp0_badvaddr=ws_badvaddr.
- Interrupt: status=32'h0040_8001, cause IP7=1.
  - First valid WB instruction one cycle later -> cp0_ex_code=5'h00.
  - Same vector with status EXL=1 -> no trap.
- ERET: cp0_epc=32'hbfc00200, ws_eret=1 -> cp0_eret pulse 1 cycle, cp0_ex_code=`NO_EX, redirect_pc=32'hbfc00200.
- Backpressure: hold fs_redirect_ready=0 for 5 cycles in REDIR -> redirect_valid and pipe_flush stay high and a second ws exception is ignored. Release -> IDLE next cycle.
- Reset mid-FLUSH: assert reset -> next cycle busy=0, pipe_flush=0, cp0_ex_code=`NO_EX.
